// File: rtl/memory_bus_sizes.sv
// Shared memory bus sizing plus the VLM request payload type.
package memory_bus_sizes;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = WORD_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic [BE_WIDTH-1:0]   be;
  } vlm_req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request FIFO; head entry is read straight from storage.
module req_fifo
  import memory_bus_sizes::*;
#(
  parameter int unsigned  DEPTH = 2,
  parameter type          T     = vlm_req_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer/count next state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vlm_req_adapter.sv
// Pipeline-to-VLM request adapter: queues requests, issues them in order,
// drives the pipeline stall and watches for a slave stuck in hold.
module vlm_req_adapter
  import memory_bus_sizes::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned HOLD_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_din,
  input  logic [BE_WIDTH-1:0]   cpu_be,
  output logic                  vlm_en,
  output logic                  vlm_we,
  output logic [ADDR_WIDTH-1:0] vlm_addr,
  output logic [WORD_WIDTH-1:0] vlm_din,
  output logic [BE_WIDTH-1:0]   vlm_be,
  input  logic                  vlm_hold,
  output logic                  new_data_coming,
  output logic                  rd_data_valid,
  output logic                  mem_stall,
  output logic                  hold_timeout
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned HOLD_W = 16;

  vlm_req_t         push_req, head_req;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;

  logic              rd_data_valid_q, rd_data_valid_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_timeout_q, hold_timeout_d;

  assign push_req  = '{we: cpu_we, addr: cpu_addr, din: cpu_din, be: cpu_be};
  assign fifo_push = cpu_req_valid && cpu_req_ready;
  assign fifo_pop  = vlm_en && !vlm_hold;

  req_fifo #(
    .DEPTH (DEPTH),
    .T     (vlm_req_t)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head      (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Issue straight from the FIFO head; the head only moves on a pop, so
  // the bus stays stable while the slave holds.
  assign cpu_req_ready   = !fifo_full;
  assign vlm_en          = !fifo_empty;
  assign vlm_we          = head_req.we;
  assign vlm_addr        = head_req.addr;
  assign vlm_din         = head_req.din;
  assign vlm_be          = head_req.be;
  assign new_data_coming = vlm_en && !vlm_we && !vlm_hold;
  assign mem_stall       = (fifo_count == CNT_W'(DEPTH)) || (vlm_en && vlm_hold)
                           || (vlm_en && !vlm_we);
  assign rd_data_valid   = rd_data_valid_q;
  assign hold_timeout    = hold_timeout_q;

  // Watchdog: count consecutive held cycles, saturate, latch the error.
  always_comb begin
    rd_data_valid_d = new_data_coming;
    hold_cnt_d      = '0;
    hold_timeout_d  = hold_timeout_q;
    if (vlm_en && vlm_hold) begin
      hold_cnt_d = (hold_cnt_q >= HOLD_W'(HOLD_LIMIT)) ? hold_cnt_q
                                                       : hold_cnt_q + HOLD_W'(1);
    end
    if (hold_cnt_d == HOLD_W'(HOLD_LIMIT)) hold_timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_valid_q <= 1'b0;
      hold_cnt_q      <= '0;
      hold_timeout_q  <= 1'b0;
    end else begin
      rd_data_valid_q <= rd_data_valid_d;
      hold_cnt_q      <= hold_cnt_d;
      hold_timeout_q  <= hold_timeout_d;
    end
  end

endmodule

// File: doc/vlm_req_adapter.md
Name: vlm_req_adapter

Overview:
- Upstream neighbour of stall_dout; sits between the pipeline memory stage and a VLM slave (cache or main memory).
- Accepts pipeline read/write requests with a valid/ready handshake and queues them in a small in-order request FIFO.
- Drives the VLM request bus from the FIFO head and produces new_data_coming for stall_dout.
- Produces mem_stall for the pipeline and detects slave hold lock-up with a watchdog counter.

Parameters:
DEPTH, 2, request FIFO entries; power of two, minimum 2.
HOLD_LIMIT, 255, consecutive vlm_hold cycles on an issued request before hold_timeout sets; 1..2**16-1.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  pipeline request present
cpu_req_ready  out  1  adapter can accept request this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  word address
cpu_din  in  WORD_WIDTH  write data
cpu_be  in  WORD_WIDTH/8  byte enables (writes only)
vlm_en  out  1  VLM request enable
vlm_we  out  1  VLM write enable
vlm_addr  out  ADDR_WIDTH  VLM address
vlm_din  out  WORD_WIDTH  VLM write data
vlm_be  out  WORD_WIDTH/8  VLM byte enables
vlm_hold  in  1  slave not accepting the current request
new_data_coming  out  1  to stall_dout; read accepted by slave this cycle
rd_data_valid  out  1  vlm dout (via stall_dout) valid this cycle
mem_stall  out  1  pipeline must freeze
hold_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (rst_n low, asynchronous): FIFO count = 0 and pointers = 0; cpu_req_ready = 1; vlm_en, new_data_coming, rd_data_valid, mem_stall and hold_timeout = 0; hold counter = 0.
- Reset asserted mid-operation flushes queued requests; vlm_en drops without waiting for a clock edge.
- Push: cpu_req_valid && cpu_req_ready writes {we, addr, din, be} at the write pointer.
- cpu_req_ready = (count < DEPTH), derived from registered count only. There is no pop-through when full: with count == DEPTH, ready stays 0 for that whole cycle even if a pop occurs.
- Issue: vlm_en = (count != 0). vlm_we, vlm_addr, vlm_din and vlm_be come from the FIFO head, driven straight from storage.
- Latency: a request pushed at edge N appears on the VLM bus in cycle N+1. There is no bypass.
- Pop: vlm_en && !vlm_hold advances the read pointer at the next edge.
- VLM no-change rule: while vlm_hold = 1, every vlm_* output is held stable.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- new_data_coming = vlm_en && !vlm_we && !vlm_hold (combinational).
- rd_data_valid = new_data_coming registered one cycle.
- Ordering: writes and reads retire strictly in push order. A read after a write to the same address sees the new data.
- mem_stall = (count == DEPTH) || (vlm_en && vlm_hold) || (vlm_en && !vlm_we). The pipeline freezes until any read at the head is accepted.
- Watchdog counter:
  - Increments each cycle vlm_en && vlm_hold; clears on any pop or when vlm_en = 0.
  - Saturates at HOLD_LIMIT. On reaching HOLD_LIMIT, hold_timeout sets and stays set until reset.
  - The request remains issued after timeout; no auto-abort.
- Writes produce neither new_data_coming nor rd_data_valid.

Decomposition:
- Shared package memory_bus_sizes supplies WORD_WIDTH and ADDR_WIDTH.
- Add to that package:
  - BE_WIDTH = WORD_WIDTH/8.
  - Packed struct vlm_req_t {we, addr, din, be}.
- Sub-module req_fifo, parameterised on DEPTH and element type vlm_req_t:
  - push/pop/full/empty/count interface.
  - Head data driven directly from storage.
  - Asynchronous active-low reset on pointers and count.
- Top level holds issue logic, stall logic, rd_data_valid register and watchdog.

Test Plan:
- Single read: push read addr 0x40, vlm_hold = 0 → vlm_en = 1, vlm_addr = 0x40 the next cycle; new_data_coming = 1 that cycle; rd_data_valid = 1 one cycle later; FIFO empties.
- Backpressure: vlm_hold = 1 for 5 cycles while pushing 3 writes (DEPTH = 2) →
  - cpu_req_ready = 0 after 2 accepted; mem_stall = 1.
  - vlm_addr and vlm_din stable for all 5 cycles.
  - After release, both writes retire in order and the third is accepted.
- Write-then-read ordering: write 0xDEADBEEF to 0x10 (be = 4'hF), then read 0x10 back-to-back → VLM sees write then read, in push order. The read yields 0xDEADBEEF through stall_dout.
- Full simultaneous push/pop: count = 2, head popped the same cycle cpu_req_valid = 1 → push refused (ready = 0); count = 1 next cycle; push accepted the following cycle.
- Watchdog: HOLD_LIMIT = 4, hold asserted 4 cycles on an issued read → hold_timeout = 1 and stays 1 after hold deasserts. Repeat with hold for 3 cycles → hold_timeout stays 0.
- Async reset mid-operation: rst_n low between edges with 2 queued requests → vlm_en = 0, cpu_req_ready = 1, mem_stall = 0 immediately. No stale request issues after rst_n returns high.
